// File: rtl/grayscale_frame_sequencer_pkg.sv
// Shared types and constants for the grayscale frame sequencer.
// Holds the FSM encoding, default latencies and a counter-width helper.
package grayscale_frame_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_e;

  localparam int DEF_MEM_LAT  = 1;
  localparam int DEF_PIPE_LAT = 2;
  localparam int TOT_LAT      = DEF_MEM_LAT + DEF_PIPE_LAT;

  // Never returns zero so single-value counters still get one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/grayscale_frame_sequencer_delay_line.sv
// Fixed-depth shift register tracking in-flight pixels.
// Carries {valid, addr, row_last} from read issue to write strobe.
module valid_delay_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d[0] = d_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign d_out = stage_q[DEPTH-1];

endmodule

// File: rtl/grayscale_frame_sequencer.sv
// Raster read sequencer for the RGB-to-grayscale pipeline.
// Issues one source read per clock and aligns write strobes to the datapath.
module grayscale_frame_sequencer
  import grayscale_frame_sequencer_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int ADDR_W   = 19,
  parameter int MEM_LAT  = DEF_MEM_LAT,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        gray_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              row_done,
  output logic              done
);

  localparam int LAT = MEM_LAT + PIPE_LAT;
  localparam int XW  = cnt_bits(IMG_W);
  localparam int YW  = cnt_bits(IMG_H);
  localparam int DW  = cnt_bits(LAT + 1);
  localparam int LW  = ADDR_W + 2;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [DW-1:0] D_LAST = DW'(LAT - 1);

  seq_state_e        state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     drain_q, drain_d;

  logic          x_last;
  logic          y_last;
  logic [LW-1:0] dl_in;
  logic [LW-1:0] dl_out;

  assign x_last = (x_q == X_LAST);
  assign y_last = (y_q == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    rd_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        x_d     = '0;
        y_d     = '0;
        addr_d  = '0;
        drain_d = '0;
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        rd_en  = 1'b1;
        busy   = 1'b1;
        addr_d = addr_q + 1'b1;
        if (x_last) begin
          x_d = '0;
          y_d = y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
        if (x_last && y_last) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        drain_d = drain_q + 1'b1;
        // Last read has left the delay line once LAT cycles have elapsed.
        if (drain_q == D_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd_addr = addr_q;
  assign dl_in   = {rd_en, addr_q, rd_en & x_last};

  valid_delay_line #(
    .DEPTH (LAT),
    .WIDTH (LW)
  ) u_dly (
    .clk   (clk),
    .rst   (rst),
    .d_in  (dl_in),
    .d_out (dl_out)
  );

  assign wr_en    = dl_out[LW-1];
  assign wr_addr  = dl_out[ADDR_W:1];
  assign row_done = dl_out[0];
  assign wr_data  = gray_in;

endmodule

// File: tb/tb_grayscale_frame_sequencer.sv
// Randomized bench for grayscale_frame_sequencer across three geometries.
// A frame-level timing model predicts every output each cycle.
module tb_grayscale_frame_sequencer;

  localparam int NDUT = 3;
  localparam int AW   = 4;

  int dw [NDUT] = '{4, 4, 1};
  int dh [NDUT] = '{3, 3, 3};
  int dl [NDUT] = '{3, 4, 3};

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;

  logic [NDUT-1:0] rd_en;
  logic [NDUT-1:0] wr_en;
  logic [NDUT-1:0] busy;
  logic [NDUT-1:0] row_done;
  logic [NDUT-1:0] done;
  logic [AW-1:0]   rd_addr [NDUT];
  logic [AW-1:0]   wr_addr [NDUT];
  logic [7:0]      gray_in [NDUT];
  logic [7:0]      wr_data [NDUT];

  logic [23:0]          mem  [16];
  logic [3:0][AW-1:0]   hist [NDUT];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int origin [NDUT] = '{-1, -1, -1};
  bit rst_prev = 1'b1;

  always #5 clk = ~clk;

  function automatic logic [7:0] gray(input logic [23:0] rgb);
    logic [15:0] s;
    s = 16'(rgb[23:16]) + 16'(rgb[15:8]) + 16'(rgb[7:0]);
    s = s * 16'd5;
    return s[11:4];
  endfunction

  // Source RAM plus datapath: pixel read L cycles ago appears at gray_in.
  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      hist[i] <= {hist[i][2:0], rd_addr[i]};
    end
  end

  assign gray_in[0] = gray(mem[hist[0][2]]);
  assign gray_in[1] = gray(mem[hist[1][3]]);
  assign gray_in[2] = gray(mem[hist[2][2]]);

  grayscale_frame_sequencer #(
    .IMG_W(4), .IMG_H(3), .ADDR_W(AW), .MEM_LAT(1), .PIPE_LAT(2)
  ) u0 (
    .clk(clk), .rst(rst), .start(start),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .gray_in(gray_in[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .busy(busy[0]), .row_done(row_done[0]), .done(done[0])
  );

  grayscale_frame_sequencer #(
    .IMG_W(4), .IMG_H(3), .ADDR_W(AW), .MEM_LAT(2), .PIPE_LAT(2)
  ) u1 (
    .clk(clk), .rst(rst), .start(start),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .gray_in(gray_in[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .busy(busy[1]), .row_done(row_done[1]), .done(done[1])
  );

  grayscale_frame_sequencer #(
    .IMG_W(1), .IMG_H(3), .ADDR_W(AW), .MEM_LAT(1), .PIPE_LAT(2)
  ) u2 (
    .clk(clk), .rst(rst), .start(start),
    .rd_en(rd_en[2]), .rd_addr(rd_addr[2]), .gray_in(gray_in[2]),
    .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]),
    .busy(busy[2]), .row_done(row_done[2]), .done(done[2])
  );

  task automatic chk(input string tag, input int d,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h",
             tag, d, cyc, obs, exp);
    end
  endtask

  // Check this cycle's outputs, then drive start/rst for the same cycle.
  task automatic step(input bit st, input bit rs);
    int k;
    int p;
    int l;
    bit e_rd;
    bit e_wr;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      p = dw[d] * dh[d];
      l = dl[d];
      k = (origin[d] < 0) ? -1000 : cyc - origin[d];
      e_rd = (k >= 0) && (k < p);
      e_wr = (k >= l) && (k < p + l);
      chk("rd_en", d, 32'(rd_en[d]), 32'(e_rd));
      chk("wr_en", d, 32'(wr_en[d]), 32'(e_wr));
      chk("busy", d, 32'(busy[d]), 32'((k >= 0) && (k < p + l)));
      chk("done", d, 32'(done[d]), 32'(k == p + l));
      chk("row_done", d, 32'(row_done[d]),
          32'(e_wr && ((k - l) % dw[d] == dw[d] - 1)));
      if (e_rd) chk("rd_addr", d, 32'(rd_addr[d]), 32'(k));
      if (e_wr) begin
        chk("wr_addr", d, 32'(wr_addr[d]), 32'(k - l));
        chk("wr_data", d, 32'(wr_data[d]), 32'(gray(mem[k - l])));
      end
      if (rst_prev) begin
        chk("rst_rd_addr", d, 32'(rd_addr[d]), 32'd0);
        chk("rst_wr_addr", d, 32'(wr_addr[d]), 32'd0);
      end
    end
    start = st;
    rst   = rs;
    for (int d = 0; d < NDUT; d++) begin
      p = dw[d] * dh[d];
      if (rs) begin
        origin[d] = -1;
      end else if (st && (origin[d] < 0 ||
                          cyc - origin[d] > p + dl[d])) begin
        origin[d] = cyc + 1;
      end
    end
    rst_prev = rs;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 24'($urandom);
    mem[0] = 24'h646464;
    mem[1] = 24'h000000;
    mem[2] = 24'hffffff;

    step(0, 1);
    step(1, 1);
    step(0, 0);
    step(0, 0);

    // Frame with a second start mid-frame, then start right after done.
    step(1, 0);
    for (int i = 0; i < 16; i++) step(i == 5, 0);
    step(1, 0);
    for (int i = 0; i < 20; i++) step(0, 0);

    // Abort during the cycle that writes address 5, then a clean frame.
    step(1, 0);
    for (int i = 0; i < 8; i++) step(0, 0);
    step(0, 1);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    for (int i = 0; i < 20; i++) step(0, 0);

    for (int i = 0; i < 120; i++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
    end
    for (int i = 0; i < 20; i++) step(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grayscale_frame_sequencer.md
Name: grayscale_frame_sequencer

Overview:
Raster-order controller for the 2-stage pipelined RGB-to-grayscale datapath. On a start pulse it sweeps an IMG_W x IMG_H source frame buffer and issues one read per clock. It tracks the memory-plus-datapath latency with a valid/address delay line and raises write strobes to the grayscale frame buffer exactly when each converted pixel appears. It reports busy, per-row and per-frame completion to the top-level capture/display control.

Parameters:
IMG_W, 640, pixels per row
IMG_H, 480, rows per frame
ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
MEM_LAT, 1, source RAM read latency in cycles (rd_en to RGB valid at datapath input)
PIPE_LAT, 2, grayscale datapath latency in cycles (RGB in to gray out)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
start  in  1  single-cycle frame request; honoured only in IDLE
rd_en  out  1  source RAM read enable
rd_addr  out  ADDR_W  source RAM address, linear raster (y*IMG_W+x)
gray_in  in  8  grayscale pixel from datapath output
wr_en  out  1  destination RAM write enable
wr_addr  out  ADDR_W  destination address, aligned with gray_in
wr_data  out  8  combinational pass-through of gray_in
busy  out  1  high in RUN and DRAIN
row_done  out  1  one-cycle pulse with the wr_en of the last pixel of each row
done  out  1  one-cycle pulse the cycle after the final wr_en of the frame

Behaviour:
- TOT_LAT = MEM_LAT + PIPE_LAT (default 3). Source RAM data feeds the datapath directly; this block only sequences.
- Reset values: rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, busy=0, row_done=0, done=0, state=IDLE, x/y counters 0, delay line cleared. wr_data follows gray_in at all times.
- States:
  - IDLE: start=1 -> RUN. Counters load 0.
  - RUN: rd_en=1 every cycle. rd_addr increments by 1, x wraps at IMG_W-1 and y increments. The cycle issuing address IMG_W*IMG_H-1 -> DRAIN.
  - DRAIN: rd_en=0. Stay until the last valid leaves the delay line (TOT_LAT cycles), then -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Timing:
  - start sampled in cycle N; first rd_en/rd_addr=0 in cycle N+1.
  - wr_en for address A asserts exactly TOT_LAT cycles after rd_en for A, with wr_addr=A.
  - Writes are contiguous: IMG_W*IMG_H consecutive wr_en cycles.
- Delay line: TOT_LAT-deep shift register carrying {valid, addr, last_in_row}. wr_en, wr_addr and row_done are taken from its output stage. No backpressure; the datapath has no enable.
- Counters: x is clog2(IMG_W) bits, y is clog2(IMG_H) bits; rd_addr is a separate incrementer. No multiplier.
- Boundaries:
  - start while busy or in DONE is ignored; no queueing.
  - start coinciding with rst: rst wins.
  - rst mid-frame aborts immediately. Next cycle shows all outputs at reset values, no wr_en, no done.
  - IMG_W=1: row_done accompanies every wr_en.
  - A new start accepted in the cycle after DONE begins a fresh frame at address 0.
- Datapath arithmetic reference for checking: gray = ((R+G+B)*5)[11:4]. Sum width is 12 bits; max 3825, no overflow.

Decomposition:
- Shared package holds the state enum (IDLE, RUN, DRAIN, DONE), TOT_LAT, and an address-width helper function.
- One natural sub-module: valid_delay_line (parameterised depth and width) carrying {valid, addr, row_last}. It is reusable for other pipelined pixel operators.

Test Plan:
- IMG_W=4, IMG_H=3: rst, start pulse -> rd_addr 0..11 on 12 consecutive cycles starting 1 cycle after start; wr_addr 0..11 starting 3 cycles later; done pulse 1 cycle after wr_addr=11; busy high 15 cycles.
- Constant RGB (100,100,100) model RAM -> every wr_data=93. RGB (255,255,255) -> 239. RGB (0,0,0) -> 0.
- IMG_W=4, IMG_H=3: row_done asserted only with wr_addr 3, 7, 11 (3 pulses total).
- Second start issued mid-frame -> ignored, exactly 12 writes, one done. Start in the cycle after done -> second frame writes addresses 0..11 again.
- rst asserted after wr_addr=5 -> next cycle wr_en=0, busy=0, rd_en=0, no done. A following start produces a full clean frame from address 0.
- MEM_LAT=2, PIPE_LAT=2 -> wr_en lags rd_en by exactly 4 cycles per address; still 12 contiguous writes.
